// File: rtl/spi_tx_master.sv
// SPI transmit-only master: frames from an external stream or an internal
// incrementing counter, with programmable clock divider and inter-frame gap.
module spi_tx_master #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV       = 2,
  parameter int unsigned GAP       = 2,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              src_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              spi_clk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int unsigned DIV_W = $clog2(2 * DIV);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned GAP_W = $clog2(GAP) + 1;

  logic [1:0]        state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0] counter, counter_nxt;
  logic [DATA_W-1:0] frame, shifted;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              spi_clk_nxt, mosi_nxt, cs_n_nxt, busy_nxt, done_nxt;

  function automatic logic first_bit(input logic [DATA_W-1:0] d);
    first_bit = LSB_FIRST ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d);
    shift_out = LSB_FIRST ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
  endfunction

  assign tx_ready = (state == S_IDLE) && !src_sel && reset;

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    counter_nxt = counter;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    spi_clk_nxt = spi_clk;
    mosi_nxt    = mosi;
    cs_n_nxt    = cs_n;
    done_nxt    = 1'b0;
    frame       = src_sel ? counter : tx_data;
    shifted     = shift_out(shreg);

    case (state)
      S_IDLE: begin
        if (src_sel || tx_valid) begin
          if (src_sel) counter_nxt = counter + DATA_W'(1);
          state_nxt   = S_SHIFT;
          shreg_nxt   = frame;
          mosi_nxt    = first_bit(frame);
          cs_n_nxt    = 1'b0;
          spi_clk_nxt = 1'b0;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (div_cnt == DIV_W'(2 * DIV - 1)) begin
          div_cnt_nxt = '0;
          spi_clk_nxt = 1'b0;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            state_nxt   = S_GAP;
            cs_n_nxt    = 1'b1;
            mosi_nxt    = 1'b0;
            done_nxt    = 1'b1;
            gap_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            shreg_nxt   = shifted;
            mosi_nxt    = first_bit(shifted);
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
          if (div_cnt == DIV_W'(DIV - 1)) spi_clk_nxt = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP - 1)) state_nxt = S_IDLE;
        else gap_cnt_nxt = gap_cnt + GAP_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and registered outputs; synchronous active-low reset aborts any frame
  always_ff @(posedge sclk) begin
    if (!reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      counter <= DATA_W'(1);
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      spi_clk <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      counter <= counter_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      spi_clk <= spi_clk_nxt;
      mosi    <= mosi_nxt;
      cs_n    <= cs_n_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master: LSB- and MSB-first instances share stimulus,
// frames are decoded from the serial pins and compared against hand-computed values.
module tb_spi_tx_master;

  logic       sclk = 1'b0;
  logic       reset, src_sel, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, spi_clk, mosi, cs_n, busy, done;
  logic       tx_ready_m, spi_clk_m, mosi_m, cs_n_m, busy_m, done_m;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int starts = 0;
  logic cs_prev = 1'b1;

  int b0, d0, s0, n;
  logic [7:0] fv, fvm;
  int flow, fhigh, frises, fbad;
  logic fend;

  always #5 sclk = ~sclk;

  spi_tx_master #(.DATA_W(8), .DIV(2), .GAP(2), .LSB_FIRST(1'b1)) u_dut (
    .sclk(sclk), .reset(reset), .src_sel(src_sel), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .spi_clk(spi_clk), .mosi(mosi),
    .cs_n(cs_n), .busy(busy), .done(done)
  );

  spi_tx_master #(.DATA_W(8), .DIV(2), .GAP(2), .LSB_FIRST(1'b0)) u_msb (
    .sclk(sclk), .reset(reset), .src_sel(src_sel), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready_m), .spi_clk(spi_clk_m), .mosi(mosi_m),
    .cs_n(cs_n_m), .busy(busy_m), .done(done_m)
  );

  always @(negedge sclk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    cs_prev <= cs_n;
    if (cs_prev === 1'b1 && cs_n === 1'b0) starts <= starts + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; counts cs_n-high cycles, then decodes one frame from both instances
  task automatic get_frame(output logic [7:0] v, output logic [7:0] vm, output int low,
                           output int high, output int rises, output int bad,
                           output logic end_ok);
    logic s [64];
    logic sm [64];
    logic prev;
    v = '0; vm = '0; low = 0; high = 0; rises = 0; bad = 0; prev = 1'b0;
    while (cs_n === 1'b1 && high < 300) begin
      high++;
      @(negedge sclk);
    end
    while (cs_n === 1'b0 && low < 64) begin
      s[low]  = mosi;
      sm[low] = mosi_m;
      if (spi_clk !== ((low % 4) >= 2)) bad++;
      if (spi_clk_m !== spi_clk || cs_n_m !== 1'b0) bad++;
      if (spi_clk === 1'b1 && prev === 1'b0) rises++;
      prev = spi_clk;
      low++;
      @(negedge sclk);
    end
    end_ok = (cs_n === 1'b1 && spi_clk === 1'b0 && mosi === 1'b0 && done === 1'b1 &&
              mosi_m === 1'b0 && done_m === 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (4 * k + 2 < low) begin
        v[k]      = s[4 * k + 2];
        vm[7 - k] = sm[4 * k + 2];
      end
    end
    for (int c = 0; c < low; c++) begin
      if (s[c] !== s[c - c % 4] || sm[c] !== sm[c - c % 4]) bad++;
    end
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] exp, input int exp_high);
    get_frame(fv, fvm, flow, fhigh, frises, fbad, fend);
    chk({tag, "_lsb_data"}, 32'(fv), 32'(exp));
    chk({tag, "_msb_data"}, 32'(fvm), 32'(exp));
    chk({tag, "_cs_low"}, flow, 32);
    chk({tag, "_rises"}, frises, 8);
    chk({tag, "_waveform"}, fbad, 0);
    chk({tag, "_end"}, 32'(fend), 1);
    if (exp_high >= 0) chk({tag, "_gap"}, fhigh, exp_high);
  endtask

  initial begin
    reset = 1'b0; src_sel = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_spi_clk", 32'(spi_clk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    @(posedge sclk); #1 reset = 1'b1;
    @(negedge sclk);
    chk("idle_tx_ready", 32'(tx_ready), 1);

    // External 0xA5, both bit orders
    b0 = busy_cnt; d0 = done_cnt;
    @(posedge sclk); #1 tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge sclk); #1 tx_valid = 1'b0;
    @(negedge sclk);
    frame_chk("a5", 8'hA5, 0);
    repeat (6) @(negedge sclk);
    chk("a5_busy_cycles", busy_cnt - b0, 34);
    chk("a5_done_pulses", done_cnt - d0, 1);

    // Counter mode: counter untouched by the external frame, so 1,2,3
    s0 = starts;
    @(posedge sclk); #1 src_sel = 1'b1;
    @(negedge sclk);
    frame_chk("cnt1", 8'h01, -1);
    frame_chk("cnt2", 8'h02, 3);
    frame_chk("cnt3", 8'h03, 3);
    @(posedge sclk); #1 src_sel = 1'b0;
    repeat (20) @(negedge sclk);
    chk("cnt_frames", starts - s0, 3);

    // Counter wrap: reset, run 254 frames, then FF,00,01
    @(posedge sclk); #1 reset = 1'b0; src_sel = 1'b1;
    @(posedge sclk); #1 reset = 1'b1;
    @(negedge sclk);
    for (int i = 0; i < 254; i++) get_frame(fv, fvm, flow, fhigh, frises, fbad, fend);
    chk("preset_last", 32'(fv), 32'hFE);
    frame_chk("wrap_ff", 8'hFF, 3);
    frame_chk("wrap_00", 8'h00, 3);
    frame_chk("wrap_01", 8'h01, 3);
    @(posedge sclk); #1 src_sel = 1'b0;
    repeat (10) @(negedge sclk);

    // tx_valid held through a frame: next payload accepted only in first IDLE cycle
    s0 = starts; d0 = done_cnt;
    @(posedge sclk); #1 tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge sclk); #1 tx_data = 8'h3C;
    @(negedge sclk);
    frame_chk("hold_a5", 8'hA5, 0);
    n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge sclk);
    end
    chk("hold_ready_delay", n, 2);
    @(posedge sclk); #1 tx_valid = 1'b0;
    @(negedge sclk);
    frame_chk("hold_3c", 8'h3C, 0);
    repeat (40) @(negedge sclk);
    chk("hold_frames", starts - s0, 2);
    chk("hold_done_pulses", done_cnt - d0, 2);

    // Reset during bit 3 aborts the frame without done
    d0 = done_cnt;
    @(posedge sclk); #1 tx_data = 8'hFF; tx_valid = 1'b1;
    @(posedge sclk); #1 tx_valid = 1'b0;
    repeat (14) @(posedge sclk);
    @(negedge sclk);
    chk("mid_spi_clk", 32'(spi_clk), 1);
    chk("mid_mosi", 32'(mosi), 1);
    chk("mid_cs_n", 32'(cs_n), 0);
    @(posedge sclk); #1 reset = 1'b0;
    @(posedge sclk);
    @(negedge sclk);
    chk("abort_cs_n", 32'(cs_n), 1);
    chk("abort_spi_clk", 32'(spi_clk), 0);
    chk("abort_mosi", 32'(mosi), 0);
    chk("abort_busy", 32'(busy), 0);
    @(posedge sclk); #1 reset = 1'b1;
    repeat (40) @(negedge sclk);
    chk("abort_no_done", done_cnt - d0, 0);

    @(posedge sclk); #1 tx_data = 8'h5A; tx_valid = 1'b1;
    @(posedge sclk); #1 tx_valid = 1'b0;
    @(negedge sclk);
    frame_chk("post_rst_5a", 8'h5A, 0);
    repeat (5) @(negedge sclk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
